// File: rtl/pwm_pkg.sv
// Types and helpers shared by the pwm block and its feeders.
package pwm_pkg;

    typedef logic [7:0] duty_t;

    localparam int DUTY_MAX_PCT = 100;

    function automatic duty_t clamp_duty(duty_t v, duty_t max_d);
        return (v > max_d) ? max_d : v;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaled down-counter producing a one-cycle tick every SCALER cycles.
module pwm_tick_gen #(
    parameter int SCALER = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CW = (SCALER > 1) ? $clog2(SCALER) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCALER - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (run) begin
                if (cnt == '0) begin
                    cnt  <= RELOAD;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// Ramps per-channel duty toward a target once per tick and
// serialises each change onto the pwm duty-update bus.
module pwm_fader
    import pwm_pkg::*;
#(
    parameter int NB_OUTPUTS       = 2,
    parameter int STEP_SCALER      = 1000000,
    parameter int STEP_SIZE        = 1,
    parameter int RESET_DUTY_CYCLE = 50,
    parameter int MAX_DUTY         = DUTY_MAX_PCT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic [$clog2(NB_OUTPUTS)-1:0] tgt_output,
    input  logic [7:0]                    tgt_duty,
    input  logic                          tgt_valid,
    output logic [$clog2(NB_OUTPUTS)-1:0] duty_output,
    output logic [7:0]                    duty_cycle,
    output logic                          duty_valid,
    output logic                          busy
);

    localparam int IW = $clog2(NB_OUTPUTS);
    localparam duty_t RST_DUTY = duty_t'(RESET_DUTY_CYCLE);
    localparam duty_t MAX_D = duty_t'(MAX_DUTY);
    localparam logic [8:0] STEP9 = 9'(STEP_SIZE);
    localparam logic [IW-1:0] LAST = IW'(NB_OUTPUTS - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          tick;
    logic          tick_pending;
    duty_t         cur [NB_OUTPUTS];
    duty_t         tgt [NB_OUTPUTS];

    logic [8:0]    cur9;
    logic [8:0]    tgt9;
    logic [8:0]    diff9;
    logic [8:0]    step9;
    duty_t         next_cur;
    logic          changed;
    logic          any_diff;
    logic          in_range;
    logic          wr_en;

    pwm_tick_gen #(
        .SCALER(STEP_SCALER)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .tick (tick)
    );

    if ((1 << IW) > NB_OUTPUTS) begin : g_rng
        assign in_range = (int'(tgt_output) < NB_OUTPUTS);
    end else begin : g_full
        assign in_range = 1'b1;
    end

    assign wr_en = tgt_valid && in_range;

    // 9-bit step toward target; step is limited to the gap so no overshoot
    always_comb begin
        cur9     = {1'b0, cur[idx]};
        tgt9     = {1'b0, tgt[idx]};
        diff9    = '0;
        step9    = '0;
        next_cur = cur[idx];
        changed  = 1'b0;
        if (cur9 < tgt9) begin
            diff9    = tgt9 - cur9;
            step9    = (diff9 < STEP9) ? diff9 : STEP9;
            next_cur = duty_t'(cur9 + step9);
            changed  = 1'b1;
        end else if (cur9 > tgt9) begin
            diff9    = cur9 - tgt9;
            step9    = (diff9 < STEP9) ? diff9 : STEP9;
            next_cur = duty_t'(cur9 - step9);
            changed  = 1'b1;
        end
    end

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NB_OUTPUTS; i++) begin
            if (cur[i] != tgt[i]) begin
                any_diff = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            tick_pending <= 1'b0;
            duty_valid   <= 1'b0;
            duty_output  <= '0;
            duty_cycle   <= '0;
            busy         <= 1'b0;
            for (int i = 0; i < NB_OUTPUTS; i++) begin
                cur[i] <= RST_DUTY;
                tgt[i] <= RST_DUTY;
            end
        end else begin
            busy       <= any_diff;
            duty_valid <= 1'b0;
            if (wr_en) begin
                tgt[tgt_output] <= clamp_duty(tgt_duty, MAX_D);
            end
            unique case (state)
                IDLE: begin
                    if (tick || tick_pending) begin
                        tick_pending <= 1'b0;
                        idx          <= '0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        tick_pending <= 1'b1;
                    end
                    if (changed) begin
                        cur[idx]    <= next_cur;
                        duty_valid  <= 1'b1;
                        duty_output <= idx;
                        duty_cycle  <= next_cur;
                    end
                    if (idx == LAST) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
